// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID register.
// Branches resolve in ID with one delay slot; flush redirects override everything.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        is_branch,
    input  logic [31:0] branch_pc,
    input  logic        flush_i,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redirect_pc;
    logic [31:0] buf_q;
    logic        redirect_pending;

    logic        accept;
    logic        capture;
    logic        granted;
    logic        resp_load;
    logic        hold_load;
    logic        load;
    logic        in_flight;
    logic [31:0] load_instr;
    logic [31:0] pc_adv;

    assign accept     = ~id_valid | ~stall_i;
    assign capture    = id_valid & is_branch & ~stall_i;
    assign granted    = (state == S_REQ) & imem_req & imem_gnt;
    assign resp_load  = (state == S_WAIT) & imem_rvalid & accept;
    assign hold_load  = (state == S_HOLD) & accept;
    assign load       = resp_load | hold_load;
    assign load_instr = hold_load ? buf_q : imem_rdata;

    // A response landing in the flush cycle is discarded outright; only a request
    // still waiting on its response after this edge needs the DROP state.
    assign in_flight  = granted | (((state == S_WAIT) | (state == S_DROP)) & ~imem_rvalid);

    // Same-cycle branch target beats a stored one; the delay slot is never squashed.
    assign pc_adv     = capture          ? branch_pc   :
                        redirect_pending ? redirect_pc : pc + 32'd4;

    assign imem_addr  = pc;
    assign pc_out     = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_REQ;
            pc               <= RESET_PC;
            imem_req         <= 1'b0;
            id_valid         <= 1'b0;
            id_instr         <= '0;
            id_pc            <= '0;
            redirect_pending <= 1'b0;
            redirect_pc      <= '0;
            buf_q            <= '0;
        end else if (flush_i) begin
            pc               <= flush_pc;
            id_valid         <= 1'b0;
            redirect_pending <= 1'b0;
            if (in_flight) begin
                state    <= S_DROP;
                imem_req <= 1'b0;
            end else begin
                state    <= S_REQ;
                imem_req <= 1'b1;
            end
        end else begin
            if (load) begin
                id_valid         <= 1'b1;
                id_instr         <= load_instr;
                id_pc            <= pc;
                pc               <= pc_adv;
                redirect_pending <= 1'b0;
            end else begin
                if (id_valid && !stall_i)
                    id_valid <= 1'b0;
                if (capture) begin
                    redirect_pending <= 1'b1;
                    redirect_pc      <= branch_pc;
                end
            end

            case (state)
                S_REQ: begin
                    if (granted) begin
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (accept) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end else begin
                            buf_q <= imem_rdata;
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule
